spi_dev_router: RTL and testbench
=================================

// Module: spi_dev_router
// PURPOSE
// - Parametrised host-SPI to N-device router: the first CMD_W bits of each host frame select a target device.
// - The rest of the frame is steered to that device's chip select, with optional LDAC hold and MISO capture.
// - Sits between the debug SPI header (aardvark) and the ADC/DAC front-ends.
// - Generalises the fixed xp-adc/xdac test decoder to NUM_DEV devices and per-device LDAC, and adds abort and error reporting.
// PARAMETERS
// NUM_DEV      4    number of routed devices (1..15)
// CMD_W        8    command prefix length, bits
// GAP_CYCLES   22   clk_ref cycles between end of command and device CSn assert (>=1)
// RX_W         16   MISO bits captured per frame from the selected device
// LDAC_MASK    4'b0010  bit i=1: device i gets LDAC held low while routed
// PORTS
// clk_ref      in   1        system clock (20 MHz), all logic on rising edge
// sys_rst      in   1        synchronous reset, active-high
// host_csn     in   1        host SPI chip select, async, active-low
// host_sck     in   1        host SPI clock, async, CPOL=CPHA=0
// host_sdi     in   1        host MOSI, async
// host_sdo     out  1        host MISO = dev_sdo[sel] while ROUTE, else 0
// dev_csn      out  NUM_DEV  per-device chip select, active-low, registered
// dev_ldac_n   out  NUM_DEV  per-device LDAC, active-low, registered
// dev_sck      out  1        host_sck passthrough (combinational, all devices)
// dev_sdi      out  1        host_sdi passthrough (combinational, all devices)
// dev_sdo      in   NUM_DEV  per-device MISO, async
// busy         out  1        1 in any state except IDLE
// rx_data      out  RX_W     MISO bits captured in last routed frame, MSB first
// rx_valid     out  1        1-cycle pulse, rx_data updated
// cmd_err      out  1        1-cycle pulse, invalid command
// frame_abort  out  1        1-cycle pulse, host_csn rose before routing
// BEHAVIOUR
// - Reset values (sys_rst high at a clk_ref edge, any state):
//   - dev_csn and dev_ldac_n all 1; busy, rx_valid, cmd_err, frame_abort 0; rx_data 0; state IDLE; counters 0.
//   - Reset mid-frame drops dev_csn immediately on that edge. The frame is not resumed; the next csn fall is needed.
// - host_csn, host_sck, host_sdi and dev_sdo pass through 2-FF synchronisers.
//   - Edges come from synced current vs previous values, so detection latency is 3 clk_ref.
// - FSM:
//   - IDLE: wait for csn fall; clear bit_cnt, cmd, rx_cnt, rx_data -> CMD.
//   - CMD: on each sck rise, cmd <= {cmd[CMD_W-2:0], sdi} and bit_cnt++.
//     - bit_cnt==CMD_W -> GAP with gap_cnt=0.
//     - csn rise -> frame_abort pulse -> IDLE.
//   - GAP: gap_cnt++ and sck edges are ignored. csn rise -> frame_abort -> IDLE.
//     - When gap_cnt==GAP_CYCLES-1, evaluate the command:
//       - cmd in 1..NUM_DEV: sel=cmd-1; dev_csn[sel]<=0; dev_ldac_n[sel]<=0 if LDAC_MASK[sel]; -> ROUTE.
//       - else: cmd_err pulse -> DRAIN.
//   - ROUTE: on sck rise with rx_cnt<RX_W, rx_data <= {rx_data[RX_W-2:0], sdo_sync[sel]} and rx_cnt++. Bits beyond RX_W are ignored.
//     - On csn rise: dev_csn and dev_ldac_n all 1; rx_valid pulse same edge -> DONE.
//   - DRAIN: ignore all until csn rise -> DONE. No rx_valid.
//   - DONE: one cycle -> IDLE. This is the min inter-frame turnaround.
// - At most one dev_csn bit is low at any time. dev_csn is never low outside ROUTE.
// - cmd=0 and cmd>NUM_DEV are invalid. cmd is compared at full CMD_W width.
// - Simultaneous csn rise and final sck rise in CMD: csn wins (abort).
// - Simultaneous csn rise and sck rise in ROUTE: capture the bit, then close the frame.
// - The host must keep sck idle during GAP; GAP_CYCLES/20 MHz is the required host pause.
// TESTING
// - cmd 8'h02, 16 sck, dev_sdo[1]=pattern 16'hA5C3 -> dev_csn=4'b1101 only; dev_ldac_n[1]=0; rx_data=16'hA5C3; rx_valid once at csn rise.
// - cmd 8'h01 -> dev_csn[0] low exactly GAP_CYCLES clk after 8th sync'd sck rise; dev_ldac_n stays 4'hF (mask bit0=0).
// - cmd 8'h00 and 8'h05 -> cmd_err pulse; dev_csn stays 4'hF whole frame; busy until csn rise+1.
// - csn rises after 5 cmd bits, and again during GAP -> frame_abort pulse each time; no dev_csn activity; next frame routes normally.
// - sys_rst asserted mid-ROUTE -> dev_csn/dev_ldac_n 4'hF on the same edge; rx_valid never pulses; new frame with cmd 8'h03 routes.
// - 24 sck in ROUTE with RX_W=16 -> rx_data holds the first 16 bits only; back-to-back frames with 1 idle clk both decode.

Source files
------------

// File: rtl/spi_dev_router.sv
// -----------------------------------------------------------------------------
// spi_dev_router
//
// Routes a host SPI port to one of NUM_DEV downstream devices. The first CMD_W
// bits clocked in after host_csn falls form a command. After a fixed pause of
// GAP_CYCLES clocks, a command of 1..NUM_DEV selects device (cmd-1). For the
// rest of the frame that device's chip select is held low. Its LDAC is also
// held low if LDAC_MASK enables it. Up to RX_W bits of the device's MISO are
// captured. Any other command is reported on cmd_err, and the frame is drained.
//
// Ports
//   clk_ref      system clock, all logic on the rising edge
//   sys_rst      synchronous reset, active-high
//   host_csn     host chip select (async, active-low)
//   host_sck     host SPI clock (async, CPOL=CPHA=0)
//   host_sdi     host MOSI (async)
//   host_sdo     host MISO: selected dev_sdo while routing, else 0
//   dev_csn      per-device chip select, active-low, registered
//   dev_ldac_n   per-device LDAC, active-low, registered
//   dev_sck      host_sck passthrough to all devices
//   dev_sdi      host_sdi passthrough to all devices
//   dev_sdo      per-device MISO (async)
//   busy         high whenever the FSM is not idle
//   rx_data      MISO bits captured in the last routed frame, MSB first
//   rx_valid     one-cycle pulse when a routed frame closes
//   cmd_err      one-cycle pulse on an invalid command
//   frame_abort  one-cycle pulse when host_csn rises before routing starts
// -----------------------------------------------------------------------------
module spi_dev_router #(
  parameter int                 NUM_DEV    = 4,
  parameter int                 CMD_W      = 8,
  parameter int                 GAP_CYCLES = 22,
  parameter int                 RX_W       = 16,
  parameter logic [NUM_DEV-1:0] LDAC_MASK  = NUM_DEV'(4'b0010)
) (
  input  logic               clk_ref,
  input  logic               sys_rst,
  input  logic               host_csn,
  input  logic               host_sck,
  input  logic               host_sdi,
  output logic               host_sdo,
  output logic [NUM_DEV-1:0] dev_csn,
  output logic [NUM_DEV-1:0] dev_ldac_n,
  output logic               dev_sck,
  output logic               dev_sdi,
  input  logic [NUM_DEV-1:0] dev_sdo,
  output logic               busy,
  output logic [RX_W-1:0]    rx_data,
  output logic               rx_valid,
  output logic               cmd_err,
  output logic               frame_abort
);

  localparam int SEL_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int BIT_W = $clog2(CMD_W + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RXC_W = $clog2(RX_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_GAP, S_ROUTE, S_DRAIN, S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers. These registers are left out of reset on purpose.
  // They keep tracking the pins while sys_rst is high. A host_csn that is
  // already low when reset releases therefore does not look like a new fall,
  // and the frame that was interrupted is not resumed.
  // ---------------------------------------------------------------------------
  logic [1:0]         csn_sync_q, sck_sync_q, sdi_sync_q;
  logic               csn_prev_q, sck_prev_q;
  logic [NUM_DEV-1:0] sdo_meta_q, sdo_sync_q;

  always_ff @(posedge clk_ref) begin
    csn_sync_q <= {csn_sync_q[0], host_csn};
    sck_sync_q <= {sck_sync_q[0], host_sck};
    sdi_sync_q <= {sdi_sync_q[0], host_sdi};
    csn_prev_q <= csn_sync_q[1];
    sck_prev_q <= sck_sync_q[1];
    sdo_meta_q <= dev_sdo;
    sdo_sync_q <= sdo_meta_q;
  end

  logic csn_rise, csn_fall, sck_rise;
  assign csn_rise =  csn_sync_q[1] & ~csn_prev_q;
  assign csn_fall = ~csn_sync_q[1] &  csn_prev_q;
  assign sck_rise =  sck_sync_q[1] & ~sck_prev_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [RXC_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [RX_W-1:0]    rx_data_q, rx_data_d;
  logic [NUM_DEV-1:0] dev_csn_q, dev_csn_d;
  logic [NUM_DEV-1:0] dev_ldac_q, dev_ldac_d;
  logic               rx_valid_q, rx_valid_d;
  logic               cmd_err_q, cmd_err_d;
  logic               frame_abort_q, frame_abort_d;

  always_ff @(posedge clk_ref) begin
    if (sys_rst) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      rx_cnt_q      <= '0;
      cmd_q         <= '0;
      sel_q         <= '0;
      rx_data_q     <= '0;
      dev_csn_q     <= '1;
      dev_ldac_q    <= '1;
      rx_valid_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      cmd_q         <= cmd_d;
      sel_q         <= sel_d;
      rx_data_q     <= rx_data_d;
      dev_csn_q     <= dev_csn_d;
      dev_ldac_q    <= dev_ldac_d;
      rx_valid_q    <= rx_valid_d;
      cmd_err_q     <= cmd_err_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  // The command is compared at full width. Zero and anything above NUM_DEV
  // are rejected.
  logic             cmd_ok;
  logic [SEL_W-1:0] cmd_sel;
  logic             gap_done, cmd_last;
  assign cmd_ok   = (cmd_q != '0) && (cmd_q <= CMD_W'(NUM_DEV));
  assign cmd_sel  = SEL_W'(cmd_q - CMD_W'(1));
  assign gap_done = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));
  assign cmd_last = (bit_cnt_q == BIT_W'(CMD_W - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic. csn rise takes priority over the final command bit.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (csn_fall) state_d = S_CMD;
      S_CMD: begin
        if (csn_rise)                  state_d = S_IDLE;
        else if (sck_rise && cmd_last) state_d = S_GAP;
      end
      S_GAP: begin
        if (csn_rise)      state_d = S_IDLE;
        else if (gap_done) state_d = cmd_ok ? S_ROUTE : S_DRAIN;
      end
      S_ROUTE: if (csn_rise) state_d = S_DONE;
      S_DRAIN: if (csn_rise) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered-output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    rx_cnt_d      = rx_cnt_q;
    cmd_d         = cmd_q;
    sel_d         = sel_q;
    rx_data_d     = rx_data_q;
    dev_csn_d     = dev_csn_q;
    dev_ldac_d    = dev_ldac_q;
    rx_valid_d    = 1'b0;
    cmd_err_d     = 1'b0;
    frame_abort_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (csn_fall) begin
          bit_cnt_d = '0;
          cmd_d     = '0;
          rx_cnt_d  = '0;
          rx_data_d = '0;
        end
      end
      S_CMD: begin
        if (csn_rise) begin
          frame_abort_d = 1'b1;
        end else if (sck_rise) begin
          cmd_d     = {cmd_q[CMD_W-2:0], sdi_sync_q[1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (cmd_last) gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (csn_rise) begin
          frame_abort_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
          if (gap_done) begin
            if (cmd_ok) begin
              sel_d              = cmd_sel;
              dev_csn_d[cmd_sel] = 1'b0;
              if (LDAC_MASK[cmd_sel]) dev_ldac_d[cmd_sel] = 1'b0;
            end else begin
              cmd_err_d = 1'b1;
            end
          end
        end
      end
      S_ROUTE: begin
        // A bit that arrives on the same edge as csn rise is still captured.
        if (sck_rise && (rx_cnt_q < RXC_W'(RX_W))) begin
          rx_data_d = {rx_data_q[RX_W-2:0], sdo_sync_q[sel_q]};
          rx_cnt_d  = rx_cnt_q + 1'b1;
        end
        if (csn_rise) begin
          dev_csn_d  = '1;
          dev_ldac_d = '1;
          rx_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy        = (state_q != S_IDLE);
  assign host_sdo    = (state_q == S_ROUTE) ? dev_sdo[sel_q] : 1'b0;
  assign dev_sck     = host_sck;
  assign dev_sdi     = host_sdi;
  assign dev_csn     = dev_csn_q;
  assign dev_ldac_n  = dev_ldac_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign cmd_err     = cmd_err_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_dev_router.sv
// -----------------------------------------------------------------------------
// tb_spi_dev_router
//
// Directed bench for spi_dev_router with its default parameters (4 devices,
// 8-bit command, 22-cycle gap, 16-bit capture, LDAC on device 1 only). Host
// pins change on the falling clk_ref edge. Pulse outputs are counted shortly
// after each rising edge. Checks run on the falling edge.
// -----------------------------------------------------------------------------
module tb_spi_dev_router;

  localparam int NUM_DEV    = 4;
  localparam int CMD_W      = 8;
  localparam int GAP_CYCLES = 22;
  localparam int RX_W       = 16;

  logic               clk_ref  = 1'b0;
  logic               sys_rst  = 1'b1;
  logic               host_csn = 1'b1;
  logic               host_sck = 1'b0;
  logic               host_sdi = 1'b0;
  logic               host_sdo;
  logic [NUM_DEV-1:0] dev_csn;
  logic [NUM_DEV-1:0] dev_ldac_n;
  logic               dev_sck;
  logic               dev_sdi;
  logic [NUM_DEV-1:0] dev_sdo  = '0;
  logic               busy;
  logic [RX_W-1:0]    rx_data;
  logic               rx_valid;
  logic               cmd_err;
  logic               frame_abort;

  spi_dev_router #(
    .NUM_DEV    (NUM_DEV),
    .CMD_W      (CMD_W),
    .GAP_CYCLES (GAP_CYCLES),
    .RX_W       (RX_W),
    .LDAC_MASK  (4'b0010)
  ) dut (
    .clk_ref     (clk_ref),
    .sys_rst     (sys_rst),
    .host_csn    (host_csn),
    .host_sck    (host_sck),
    .host_sdi    (host_sdi),
    .host_sdo    (host_sdo),
    .dev_csn     (dev_csn),
    .dev_ldac_n  (dev_ldac_n),
    .dev_sck     (dev_sck),
    .dev_sdi     (dev_sdi),
    .dev_sdo     (dev_sdo),
    .busy        (busy),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .cmd_err     (cmd_err),
    .frame_abort (frame_abort)
  );

  always #25 clk_ref = ~clk_ref;

  int compared   = 0;
  int mismatched = 0;

  // Event counters, sampled 5 ns after each rising edge.
  int n_rxv   = 0;
  int n_err   = 0;
  int n_abt   = 0;
  int n_act   = 0;
  int n_multi = 0;

  always @(posedge clk_ref) begin
    #5;
    if (!sys_rst) begin
      if (rx_valid)    n_rxv++;
      if (cmd_err)     n_err++;
      if (frame_abort) n_abt++;
      if (dev_csn != 4'hF) n_act++;
      if ($countones(~dev_csn) > 1) n_multi++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_ref);
  endtask

  // One SPI bit: sck low with data set, then sck high, 3 clk_ref each.
  task automatic sck_bit(input logic mosi, input logic miso, input int dev);
    host_sck = 1'b0;
    host_sdi = mosi;
    if (dev >= 0) dev_sdo[dev] = miso;
    wait_clk(3);
    host_sck = 1'b1;
    wait_clk(3);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) sck_bit(c[i], 1'b0, -1);
  endtask

  task automatic send_data(input logic [31:0] p, input int n, input int dev);
    for (int i = n - 1; i >= 0; i--) sck_bit(1'b0, p[i], dev);
  endtask

  task automatic open_frame();
    host_csn = 1'b0;
    wait_clk(4);
  endtask

  task automatic close_frame();
    host_sck = 1'b0;
    host_csn = 1'b1;
    wait_clk(6);
    dev_sdo  = '0;
  endtask

  int s_rxv, s_err, s_abt, s_act;
  logic [7:0] bad_cmds [2];

  initial begin
    bad_cmds[0] = 8'h00;
    bad_cmds[1] = 8'h05;

    // ---------------- reset state ----------------
    wait_clk(5);
    chk("rst_dev_csn",  32'(dev_csn),     32'hF);
    chk("rst_ldac",     32'(dev_ldac_n),  32'hF);
    chk("rst_busy",     32'(busy),        32'h0);
    chk("rst_rx_valid", 32'(rx_valid),    32'h0);
    chk("rst_cmd_err",  32'(cmd_err),     32'h0);
    chk("rst_abort",    32'(frame_abort), 32'h0);
    chk("rst_rx_data",  32'(rx_data),     32'h0);
    sys_rst = 1'b0;
    wait_clk(3);

    // ---------------- cmd 02, device 1, pattern A5C3 ----------------
    s_rxv = n_rxv;
    open_frame();
    send_cmd(8'h02);
    wait_clk(30);
    chk("a_dev_csn", 32'(dev_csn),    32'hD);
    chk("a_ldac",    32'(dev_ldac_n), 32'hD);
    chk("a_busy",    32'(busy),       32'h1);
    dev_sdo = 4'b0010;
    wait_clk(1);
    chk("a_sdo_sel1", 32'(host_sdo), 32'h1);
    dev_sdo = 4'b1101;
    wait_clk(1);
    chk("a_sdo_sel0", 32'(host_sdo), 32'h0);
    dev_sdo = '0;
    send_data(32'hA5C3, 16, 1);
    close_frame();
    chk("a_rx_data",  32'(rx_data),     32'hA5C3);
    chk("a_rx_valid", 32'(n_rxv - s_rxv), 32'd1);
    chk("a_csn_end",  32'(dev_csn),     32'hF);
    chk("a_ldac_end", 32'(dev_ldac_n),  32'hF);
    chk("a_busy_end", 32'(busy),        32'h0);
    wait_clk(2);

    // ---------------- cmd 01: CSn timing after last synced sck rise -------
    open_frame();
    for (int i = 7; i >= 1; i--) sck_bit(1'b0, 1'b0, -1);
    host_sck = 1'b0;
    host_sdi = 1'b1;
    wait_clk(3);
    host_sck = 1'b1;
    // Edge seen on the 3rd rising edge, CSn low GAP_CYCLES edges later.
    wait_clk(2 + GAP_CYCLES);
    chk("b_csn_early", 32'(dev_csn), 32'hF);
    wait_clk(1);
    chk("b_csn_on",    32'(dev_csn),    32'hE);
    chk("b_ldac",      32'(dev_ldac_n), 32'hF);
    wait_clk(2);
    send_data(32'h1234, 16, 0);
    close_frame();
    chk("b_rx_data", 32'(rx_data), 32'h1234);
    wait_clk(2);

    // ---------------- invalid commands 00 and 05 ----------------
    for (int k = 0; k < 2; k++) begin
      s_err = n_err;
      s_act = n_act;
      s_rxv = n_rxv;
      open_frame();
      send_cmd(bad_cmds[k]);
      wait_clk(30);
      chk("c_dev_csn", 32'(dev_csn),       32'hF);
      chk("c_busy",    32'(busy),          32'h1);
      chk("c_cmd_err", 32'(n_err - s_err), 32'd1);
      send_data(32'hFFFF, 16, 0);
      host_sck = 1'b0;
      host_csn = 1'b1;
      wait_clk(3);
      chk("c_busy_done", 32'(busy), 32'h1);
      wait_clk(1);
      chk("c_busy_idle", 32'(busy),          32'h0);
      chk("c_no_csn",    32'(n_act - s_act), 32'd0);
      chk("c_no_rxv",    32'(n_rxv - s_rxv), 32'd0);
      dev_sdo = '0;
      wait_clk(2);
    end

    // ---------------- aborts: during CMD, then during GAP ----------------
    s_abt = n_abt;
    s_act = n_act;
    open_frame();
    for (int i = 0; i < 5; i++) sck_bit(1'b1, 1'b0, -1);
    close_frame();
    chk("d_abort_cmd", 32'(n_abt - s_abt), 32'd1);
    chk("d_busy_cmd",  32'(busy),          32'h0);
    open_frame();
    send_cmd(8'h02);
    wait_clk(5);
    close_frame();
    chk("d_abort_gap", 32'(n_abt - s_abt), 32'd2);
    chk("d_no_csn",    32'(n_act - s_act), 32'd0);
    open_frame();
    send_cmd(8'h04);
    wait_clk(30);
    chk("d_dev_csn", 32'(dev_csn),    32'h7);
    chk("d_ldac",    32'(dev_ldac_n), 32'hF);
    send_data(32'h5A0F, 16, 3);
    close_frame();
    chk("d_rx_data", 32'(rx_data), 32'h5A0F);
    wait_clk(2);

    // ---------------- reset in the middle of ROUTE ----------------
    s_rxv = n_rxv;
    open_frame();
    send_cmd(8'h03);
    wait_clk(30);
    chk("e_dev_csn", 32'(dev_csn), 32'hB);
    send_data(32'hA5, 8, 2);
    sys_rst = 1'b1;
    wait_clk(1);
    chk("e_rst_csn",  32'(dev_csn),    32'hF);
    chk("e_rst_ldac", 32'(dev_ldac_n), 32'hF);
    chk("e_rst_busy", 32'(busy),       32'h0);
    chk("e_rst_rx",   32'(rx_data),    32'h0);
    wait_clk(2);
    sys_rst = 1'b0;
    wait_clk(5);
    chk("e_no_resume", 32'(busy), 32'h0);
    close_frame();
    chk("e_no_rxv",  32'(n_rxv - s_rxv), 32'd0);
    chk("e_csn_off", 32'(dev_csn),       32'hF);
    open_frame();
    send_cmd(8'h03);
    wait_clk(30);
    chk("e_dev_csn2", 32'(dev_csn), 32'hB);
    send_data(32'hC0DE, 16, 2);
    close_frame();
    chk("e_rx_data", 32'(rx_data), 32'hC0DE);
    wait_clk(2);

    // ---------------- 24 sck in ROUTE, then back-to-back frame ------------
    s_rxv = n_rxv;
    open_frame();
    send_cmd(8'h02);
    wait_clk(30);
    send_data(32'hABCDEF, 24, 1);
    host_sck = 1'b0;
    host_csn = 1'b1;
    wait_clk(2);
    host_csn = 1'b0;
    wait_clk(1);
    chk("f_rx_valid", 32'(rx_valid), 32'h1);
    chk("f_rx_data",  32'(rx_data),  32'hABCD);
    wait_clk(3);
    chk("f_busy_b2b", 32'(busy), 32'h1);
    dev_sdo = '0;
    send_cmd(8'h01);
    wait_clk(30);
    chk("f_dev_csn", 32'(dev_csn), 32'hE);
    send_data(32'h0F0F, 16, 0);
    close_frame();
    chk("f_rx_data2", 32'(rx_data),       32'h0F0F);
    chk("f_rxv_cnt",  32'(n_rxv - s_rxv), 32'd2);
    chk("g_one_hot",  32'(n_multi),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
